// File: rtl/fproc_pkg.sv
// Shared definitions for the fproc measurement responder: port state encoding,
// default widths and the response-data formatting rule.
package fproc_pkg;

   localparam int DEF_N_CORES = 4;
   localparam int DEF_N_MEAS  = 8;
   localparam int DEF_ID_W    = 8;
   localparam int DEF_DATA_W  = 32;

   // The measurement bit lands in this position; every other data bit is zero.
   localparam int RESP_BIT_POS = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } port_state_e;

endpackage

// File: rtl/fproc_resp_port.sv
// One core's response port: latches the requested channel id, waits until that
// channel is valid, then emits a registered one-cycle ready with the captured bit.
module fproc_resp_port
   import fproc_pkg::*;
#(
   parameter int N_MEAS = DEF_N_MEAS,
   parameter int ID_W   = DEF_ID_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_i,
   input  logic [ID_W-1:0]   id_i,
   input  logic [N_MEAS-1:0] val_i,
   input  logic [N_MEAS-1:0] bit_i,
   output logic              ready_o,
   output logic [DATA_W-1:0] data_o,
   output logic [1:0]        state_o
);

   localparam int IDX_W = (N_MEAS > 1) ? $clog2(N_MEAS) : 1;

   port_state_e       state_q, state_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic              ready_q, ready_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [IDX_W-1:0]  idx;
   logic              in_range;

   assign idx      = id_q[IDX_W-1:0];
   assign in_range = (id_q < ID_W'(N_MEAS));

   // Handshake: req_i is a strobe honoured only in IDLE; ready_o is a one-cycle
   // pulse and data_o is zero in every cycle where ready_o is low.
   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      ready_d = 1'b0;
      data_d  = '0;
      case (state_q)
         ST_IDLE: begin
            if (req_i) begin
               id_d    = id_i;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!in_range) begin
               state_d = ST_RESP;
               ready_d = 1'b1;
            end else if (val_i[idx]) begin
               state_d              = ST_RESP;
               ready_d              = 1'b1;
               data_d[RESP_BIT_POS] = bit_i[idx];
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         id_q    <= '0;
         ready_q <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         ready_q <= ready_d;
         data_q  <= data_d;
      end
   end

   assign ready_o = ready_q;
   assign data_o  = data_q;
   assign state_o = state_q;

endmodule

// File: rtl/fproc_meas_resp.sv
// Function-processor measurement responder: per-channel valid/bit store shared
// by N_CORES independent response ports.
module fproc_meas_resp
   import fproc_pkg::*;
#(
   parameter int N_CORES = DEF_N_CORES,
   parameter int N_MEAS  = DEF_N_MEAS,
   parameter int ID_W    = DEF_ID_W,
   parameter int DATA_W  = DEF_DATA_W
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_CORES-1:0]        fproc_req,
   input  logic [N_CORES*ID_W-1:0]   fproc_id,
   output logic [N_CORES-1:0]        fproc_ready,
   output logic [N_CORES*DATA_W-1:0] fproc_data,
   input  logic [N_MEAS-1:0]         meas_valid,
   input  logic [N_MEAS-1:0]         meas_bit,
   input  logic                      meas_clear,
   output logic [N_CORES*2-1:0]      dbg_state
);

   logic [N_MEAS-1:0] val_q, val_d;
   logic [N_MEAS-1:0] bit_q, bit_d;

   // A fresh result in the same cycle as a clear survives for its own channel.
   always_comb begin
      val_d = meas_clear ? meas_valid : (val_q | meas_valid);
      bit_d = (bit_q & ~meas_valid) | (meas_bit & meas_valid);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         val_q <= '0;
         bit_q <= '0;
      end else begin
         val_q <= val_d;
         bit_q <= bit_d;
      end
   end

   for (genvar i = 0; i < N_CORES; i++) begin : g_port
      fproc_resp_port #(
         .N_MEAS (N_MEAS),
         .ID_W   (ID_W),
         .DATA_W (DATA_W)
      ) u_port (
         .clk     (clk),
         .reset   (reset),
         .req_i   (fproc_req[i]),
         .id_i    (fproc_id[i*ID_W +: ID_W]),
         .val_i   (val_q),
         .bit_i   (bit_q),
         .ready_o (fproc_ready[i]),
         .data_o  (fproc_data[i*DATA_W +: DATA_W]),
         .state_o (dbg_state[i*2 +: 2])
      );
   end

endmodule

// File: tb/tb_fproc_meas_resp.sv
// Directed bench for fproc_meas_resp: a vector table of single-core requests
// followed by hand-written multi-cycle sequences.
module tb_fproc_meas_resp;

   logic         clk = 1'b0;
   logic         reset;
   logic [3:0]   fproc_req;
   logic [31:0]  fproc_id;
   logic [3:0]   fproc_ready;
   logic [127:0] fproc_data;
   logic [7:0]   meas_valid;
   logic [7:0]   meas_bit;
   logic         meas_clear;
   logic [7:0]   dbg_state;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int          core;
      int          id;
      bit          pre_set;
      bit          pre_bit;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs[9];

   fproc_meas_resp dut (
      .clk         (clk),
      .reset       (reset),
      .fproc_req   (fproc_req),
      .fproc_id    (fproc_id),
      .fproc_ready (fproc_ready),
      .fproc_data  (fproc_data),
      .meas_valid  (meas_valid),
      .meas_bit    (meas_bit),
      .meas_clear  (meas_clear),
      .dbg_state   (dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic req(input int core, input int id);
      fproc_req[core]          = 1'b1;
      fproc_id[core*8 +: 8]    = 8'(id);
      step();
      fproc_req                = '0;
   endtask

   task automatic meas(input int ch, input bit b);
      meas_valid[ch] = 1'b1;
      meas_bit[ch]   = b;
      step();
      meas_valid     = '0;
      meas_bit       = '0;
   endtask

   // Called in the cycle after the request was sampled.
   task automatic expect_resp(input int core, input logic [31:0] exp, input string name);
      chk({name, "_early"}, fproc_ready, 0);
      step();
      chk({name, "_rdy"}, fproc_ready, 128'(1 << core));
      chk({name, "_data"}, fproc_data[core*32 +: 32], exp);
      step();
      chk({name, "_after"}, fproc_ready, 0);
      chk({name, "_zero"}, fproc_data, 0);
   endtask

   initial begin
      vecs[0] = '{core: 0, id: 3,   pre_set: 1, pre_bit: 1, exp_data: 32'h1};
      vecs[1] = '{core: 1, id: 3,   pre_set: 0, pre_bit: 0, exp_data: 32'h1};
      vecs[2] = '{core: 2, id: 4,   pre_set: 1, pre_bit: 0, exp_data: 32'h0};
      vecs[3] = '{core: 3, id: 7,   pre_set: 1, pre_bit: 1, exp_data: 32'h1};
      vecs[4] = '{core: 0, id: 200, pre_set: 0, pre_bit: 0, exp_data: 32'h0};
      vecs[5] = '{core: 1, id: 8,   pre_set: 0, pre_bit: 0, exp_data: 32'h0};
      vecs[6] = '{core: 2, id: 255, pre_set: 0, pre_bit: 0, exp_data: 32'h0};
      vecs[7] = '{core: 3, id: 0,   pre_set: 1, pre_bit: 1, exp_data: 32'h1};
      vecs[8] = '{core: 1, id: 4,   pre_set: 1, pre_bit: 1, exp_data: 32'h1};

      reset      = 1'b1;
      fproc_req  = '0;
      fproc_id   = '0;
      meas_valid = '0;
      meas_bit   = '0;
      meas_clear = 1'b0;
      repeat (3) step();
      chk("reset_ready", fproc_ready, 0);
      chk("reset_data", fproc_data, 0);
      chk("reset_state", dbg_state, 0);
      reset = 1'b0;
      step();

      for (int i = 0; i < 9; i++) begin
         if (vecs[i].pre_set) meas(vecs[i].id, vecs[i].pre_bit);
         step();
         req(vecs[i].core, vecs[i].id);
         expect_resp(vecs[i].core, vecs[i].exp_data, $sformatf("vec%0d", i));
      end

      // Wait for a result that arrives much later.
      req(1, 2);
      for (int k = 0; k < 15; k++) begin
         chk("wait_noready", fproc_ready, 0);
         step();
      end
      meas_valid[2] = 1'b1;
      meas_bit[2]   = 1'b0;
      step();
      meas_valid = '0;
      expect_resp(1, 32'h0, "wait_resp");

      // Shared channel: all cores in the same cycle.
      meas(5, 1'b1);
      fproc_req = 4'hF;
      fproc_id  = {4{8'd5}};
      step();
      fproc_req = '0;
      chk("shared_early", fproc_ready, 0);
      step();
      chk("shared_rdy", fproc_ready, 4'hF);
      chk("shared_data", fproc_data, {4{32'h1}});
      step();
      chk("shared_after", fproc_ready, 0);

      // Clear/set collision.
      meas(0, 1'b1);
      meas_clear    = 1'b1;
      meas_valid[1] = 1'b1;
      meas_bit[1]   = 1'b1;
      step();
      meas_clear = 1'b0;
      meas_valid = '0;
      meas_bit   = '0;
      req(0, 1);
      expect_resp(0, 32'h1, "coll_set");
      req(1, 0);
      for (int k = 0; k < 5; k++) begin
         chk("coll_stall", fproc_ready, 0);
         step();
      end
      meas(0, 1'b0);
      expect_resp(1, 32'h0, "coll_release");

      // Back-to-back requests from one core.
      req(3, 1);
      expect_resp(3, 32'h1, "b2b_first");
      req(3, 1);
      expect_resp(3, 32'h1, "b2b_second");

      // Bit changes after capture must not alter the pending response.
      req(2, 1);
      chk("late_early", fproc_ready, 0);
      meas_valid[1] = 1'b1;
      meas_bit[1]   = 1'b0;
      step();
      meas_valid = '0;
      chk("late_rdy", fproc_ready, 4'b0100);
      chk("late_data", fproc_data[64 +: 32], 32'h1);
      step();
      chk("late_after", fproc_ready, 0);
      req(0, 1);
      expect_resp(0, 32'h0, "late_newbit");

      // Reset while a port is waiting.
      req(2, 6);
      step();
      step();
      chk("rst_wait", fproc_ready, 0);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rst_state", dbg_state, 0);
      chk("rst_ready", fproc_ready, 0);
      meas(6, 1'b1);
      for (int k = 0; k < 4; k++) begin
         chk("rst_dropped", fproc_ready, 0);
         step();
      end
      req(2, 6);
      expect_resp(2, 32'h1, "rst_newreq");
      req(0, 3);
      for (int k = 0; k < 3; k++) begin
         chk("rst_valcleared", fproc_ready, 0);
         step();
      end
      meas(3, 1'b0);
      expect_resp(0, 32'h0, "rst_release");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
